// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, drives the MMU search port, issues
// instruction SRAM requests and hands {pc, exception} to the IF stage.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_flush,
  input  logic [31:0] wb_target,
  output logic [31:0] pre_if_vaddr,
  input  logic [31:0] pre_if_addr,
  input  logic [2:0]  s0_exc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  output logic        ps_to_fs_valid,
  output logic [31:0] ps_pc,
  output logic [3:0]  ps_exc
);

  typedef enum logic {
    ST_RUN,
    ST_BLOCKED
  } state_t;

  logic [31:0] r_pc;
  logic        r_ps_valid;
  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_adef;
  logic        w_has_exc;
  logic        w_redirect;
  logic        w_run;
  logic        w_req;
  logic        w_ready_go;
  logic        w_fire;
  logic [31:0] w_pc_nxt;

  assign w_adef     = r_ps_valid & (r_pc[1:0] != 2'b00);
  assign w_has_exc  = w_adef | (|s0_exc);
  assign w_redirect = wb_flush | br_taken;
  assign w_run      = (r_state == ST_RUN);

  assign w_req = r_ps_valid & w_run & fs_allowin & ~br_stall
               & ~w_redirect & ~w_has_exc;

  // A faulting fetch is handed to IF without touching the SRAM.
  assign w_ready_go = (w_req & inst_sram_addr_ok)
                    | (w_run & w_has_exc & fs_allowin & ~w_redirect & ~br_stall);
  assign w_fire     = r_ps_valid & w_ready_go;

  assign pre_if_vaddr   = r_pc;
  assign inst_sram_req  = w_req & ~reset;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_addr = pre_if_addr;
  assign ps_to_fs_valid = w_fire & ~reset;
  assign ps_pc          = r_pc;
  assign ps_exc         = {w_adef, w_adef ? 3'b000 : s0_exc};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (wb_flush) begin
      w_pc_nxt    = wb_target;
      w_state_nxt = ST_RUN;
    end else if (br_taken) begin
      w_pc_nxt = br_target;
    end else if (!r_ps_valid) begin
      // Leaving reset: step from RESET_PC-4 onto RESET_PC.
      w_pc_nxt = r_pc + 32'd4;
    end else if (w_fire) begin
      w_pc_nxt = r_pc + 32'd4;
      if (w_has_exc) begin
        w_state_nxt = ST_BLOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC - 32'd4;
      r_ps_valid <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      r_pc       <= w_pc_nxt;
      r_ps_valid <= 1'b1;
      r_state    <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: directed scenarios plus a randomized
// run against a behavioural fetch-PC model.
module tb_pre_if_stage;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_flush;
  logic [31:0] wb_target;
  logic [31:0] pre_if_vaddr;
  logic [31:0] pre_if_addr;
  logic [2:0]  s0_exc;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        ps_to_fs_valid;
  logic [31:0] ps_pc;
  logic [3:0]  ps_exc;
  logic [31:0] xmask;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  // MMU stand-in: translation is an XOR with a bench-chosen mask.
  assign pre_if_addr = pre_if_vaddr ^ xmask;

  pre_if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .br_stall(br_stall),
    .br_taken(br_taken), .br_target(br_target), .wb_flush(wb_flush),
    .wb_target(wb_target), .pre_if_vaddr(pre_if_vaddr), .pre_if_addr(pre_if_addr),
    .s0_exc(s0_exc), .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .ps_to_fs_valid(ps_to_fs_valid),
    .ps_pc(ps_pc), .ps_exc(ps_exc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; fs_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0;
    br_target = '0; wb_flush = 1'b0; wb_target = '0; s0_exc = '0;
    inst_sram_addr_ok = 1'b1; xmask = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", inst_sram_req); end
    checks++; if (ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ps_to_fs_valid); end
    checks++; if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10) begin errors++; $display("FAIL reset_consts got=%b/%b exp=0/10", inst_sram_wr, inst_sram_size); end
    reset = 1'b0;
    #1;
    checks++; if (pre_if_vaddr !== RPC - 32'd4) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pre_if_vaddr, RPC - 32'd4); end
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_first_req got=%b exp=0", inst_sram_req); end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [2];
    exp_a[0] = 32'h1c000000; exp_a[1] = 32'h1c000004;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== exp_a[i]) begin errors++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, inst_sram_req, inst_sram_addr, exp_a[i]); end
      checks++; if (ps_to_fs_valid !== 1'b1 || ps_exc !== 4'b0000 || ps_pc !== exp_a[i]) begin errors++; $display("FAIL seq_out%0d got=%b/%h/%h exp=1/0/%h", i, ps_to_fs_valid, ps_exc, ps_pc, exp_a[i]); end
      if (i == 0) tick();
    end
  endtask

  task automatic test_addr_ok_stall();
    inst_sram_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (inst_sram_req !== 1'b1 || pre_if_vaddr !== 32'h1c000004 || ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL stall%0d got=req%b pc%h v%b exp=req1 pc1c000004 v0", i, inst_sram_req, pre_if_vaddr, ps_to_fs_valid); end
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    #1;
    checks++; if (ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", ps_to_fs_valid); end
    tick();
    checks++; if (pre_if_vaddr !== 32'h1c000008 || inst_sram_req !== 1'b1) begin errors++; $display("FAIL stall_next got=%h/%b exp=1c000008/1", pre_if_vaddr, inst_sram_req); end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_target = 32'h1c000100;
    #1;
    checks++; if (inst_sram_req !== 1'b0 || ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL br_cycle got=%b/%b exp=0/0", inst_sram_req, ps_to_fs_valid); end
    tick();
    br_taken = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin errors++; $display("FAIL br_target got=%b/%h exp=1/1c000100", inst_sram_req, inst_sram_addr); end
    wb_flush = 1'b1; wb_target = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000300;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL both_cycle got=%b exp=0", inst_sram_req); end
    tick();
    wb_flush = 1'b0; br_taken = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c008000) begin errors++; $display("FAIL flush_wins got=%b/%h exp=1/1c008000", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_adef_block();
    wb_flush = 1'b1; wb_target = 32'h1c000102;
    tick();
    wb_flush = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b0 || ps_to_fs_valid !== 1'b1 || ps_exc !== 4'b1000) begin errors++; $display("FAIL adef_present got=req%b v%b exc%b exp=req0 v1 exc1000", inst_sram_req, ps_to_fs_valid, ps_exc); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (inst_sram_req !== 1'b0 || ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL blocked%0d got=%b/%b exp=0/0", i, inst_sram_req, ps_to_fs_valid); end
      tick();
    end
    br_taken = 1'b1; br_target = 32'h1c000400;
    tick();
    br_taken = 1'b0;
    #1;
    checks++; if (pre_if_vaddr !== 32'h1c000400 || ps_to_fs_valid !== 1'b0 || inst_sram_req !== 1'b0) begin errors++; $display("FAIL blocked_br got=%h/%b/%b exp=1c000400/0/0", pre_if_vaddr, ps_to_fs_valid, inst_sram_req); end
    wb_flush = 1'b1; wb_target = 32'h1c000200;
    tick();
    wb_flush = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin errors++; $display("FAIL unblock got=%b/%h exp=1/1c000200", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_tlb_exc_backpressure();
    br_taken = 1'b1; br_target = 32'h00400000;
    tick();
    br_taken = 1'b0; fs_allowin = 1'b0; s0_exc = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (inst_sram_req !== 1'b0 || ps_to_fs_valid !== 1'b0 || pre_if_vaddr !== 32'h00400000) begin errors++; $display("FAIL bp%0d got=req%b v%b pc%h exp=req0 v0 pc00400000", i, inst_sram_req, ps_to_fs_valid, pre_if_vaddr); end
      tick();
    end
    fs_allowin = 1'b1;
    #1;
    checks++; if (ps_to_fs_valid !== 1'b1 || ps_exc !== 4'b0001 || inst_sram_req !== 1'b0) begin errors++; $display("FAIL tlbr_present got=v%b exc%b req%b exp=v1 exc0001 req0", ps_to_fs_valid, ps_exc, inst_sram_req); end
    tick();
    #1;
    checks++; if (ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL tlbr_once got=%b exp=0", ps_to_fs_valid); end
    s0_exc = '0;
  endtask

  task automatic test_wrap_and_reset();
    wb_flush = 1'b1; wb_target = 32'hfffffffc;
    tick();
    wb_flush = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", inst_sram_req, inst_sram_addr); end
    tick();
    checks++; if (pre_if_vaddr !== 32'h00000000) begin errors++; $display("FAIL wrap_pc got=%h exp=00000000", pre_if_vaddr); end
    inst_sram_addr_ok = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL midreset_req got=%b exp=0", inst_sram_req); end
    tick();
    reset = 1'b0; inst_sram_addr_ok = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0 || pre_if_vaddr !== RPC - 32'd4) begin errors++; $display("FAIL midreset_state got=%b/%h exp=0/%h", inst_sram_req, pre_if_vaddr, RPC - 32'd4); end
    tick();
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin errors++; $display("FAIL restart got=%b/%h exp=1/%h", inst_sram_req, inst_sram_addr, RPC); end
  endtask

  // Random run against a model of the fetch-PC rules.
  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_valid, m_blocked;
    logic        e_adef, e_exc, e_req, e_go, rd;
    logic [3:0]  e_psexc;
    idle();
    xmask = 32'h00f0_0000;
    reset = 1'b1;
    tick();
    m_pc = RPC - 32'd4; m_valid = 1'b0; m_blocked = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset             = ($urandom_range(0, 99) == 0);
      fs_allowin        = ($urandom_range(0, 3) != 0);
      br_stall          = ($urandom_range(0, 7) == 0);
      br_taken          = ($urandom_range(0, 9) == 0);
      wb_flush          = ($urandom_range(0, 14) == 0);
      br_target         = {$urandom_range(0, 3) == 0 ? 32'hffff_fff0 : 32'h1c00_0000} + {$urandom_range(0, 63), 2'b00};
      wb_target         = 32'h1c00_0000 + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255)) : {22'd0, 8'($urandom_range(0, 255)), 2'b00});
      s0_exc            = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      inst_sram_addr_ok = ($urandom_range(0, 2) != 0);
      #1;
      e_adef  = m_valid && (m_pc[1:0] != 2'b00);
      e_exc   = e_adef || (s0_exc != 3'b000);
      rd      = wb_flush || br_taken;
      e_req   = !reset && m_valid && !m_blocked && fs_allowin && !br_stall && !rd && !e_exc;
      e_go    = !reset && m_valid && !m_blocked && fs_allowin && !br_stall && !rd
                && (e_exc || inst_sram_addr_ok);
      e_psexc = e_adef ? 4'b1000 : {1'b0, s0_exc};
      checks++;
      if (inst_sram_req !== e_req || ps_to_fs_valid !== e_go || pre_if_vaddr !== m_pc
          || ps_pc !== m_pc || inst_sram_addr !== (m_pc ^ xmask) || ps_exc !== e_psexc) begin
        errors++;
        $display("FAIL rand%0d got=req%b v%b pc%h addr%h exc%b exp=req%b v%b pc%h addr%h exc%b",
                 c, inst_sram_req, ps_to_fs_valid, pre_if_vaddr, inst_sram_addr, ps_exc,
                 e_req, e_go, m_pc, m_pc ^ xmask, e_psexc);
      end
      if (reset) begin
        m_pc = RPC - 32'd4; m_valid = 1'b0; m_blocked = 1'b0;
      end else begin
        if (wb_flush) begin m_pc = wb_target; m_blocked = 1'b0; end
        else if (br_taken) m_pc = br_target;
        else if (!m_valid) m_pc = m_pc + 32'd4;
        else if (e_go) begin m_pc = m_pc + 32'd4; if (e_exc) m_blocked = 1'b1; end
        m_valid = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_addr_ok_stall();
    test_branch();
    test_adef_block();
    test_tlb_exc_backpressure();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
